// File: rtl/branch_sequencer.sv
// Branch/vector sequencer for the MOSby 6502 core: branch condition test, relative PCL
// computation with page-cross fix-up, and reset/NMI/IRQ vector fetch sequencing.
// Optional build macro: BRANCH_BRA_EN (branch_op 8 = BRA, always taken).
module branch_sequencer #(
  parameter int                ADDR_W  = 16,
  parameter int                C_BIT   = 7,
  parameter int                Z_BIT   = 6,
  parameter int                V_BIT   = 2,
  parameter int                N_BIT   = 0,
  parameter int                I_BIT   = 5,
  parameter logic [ADDR_W-1:0] RST_VEC = 16'hFFFC,
  parameter logic [ADDR_W-1:0] NMI_VEC = 16'hFFFA,
  parameter logic [ADDR_W-1:0] IRQ_VEC = 16'hFFFE
) (
  input  logic              clk_2,
  input  logic              rst,
  input  logic              branch_con,
  input  logic              branch_uncon,
  input  logic [3:0]        branch_op,
  input  logic [7:0]        status,
  input  logic [7:0]        pcl,
  input  logic [7:0]        offset,
  input  logic              nmi_req,
  input  logic              irq_req,
  input  logic              instr_boundary,
  output logic              branch,
  output logic              lower_byte,
  output logic              normal,
  output logic [ADDR_W-1:0] vec_addr,
  output logic [7:0]        pcl_new,
  output logic              pch_inc,
  output logic              pch_dec,
  output logic              busy
);

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    IDLE   = 2'd2,
    BR_FIX = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              nmi_prev;
  logic              nmi_pend;
  logic              nmi_pend_nx;
  logic              nmi_edge;
  logic              branch_nx;
  logic              lower_byte_nx;
  logic              normal_nx;
  logic [ADDR_W-1:0] vec_addr_nx;
  logic [7:0]        pcl_new_nx;
  logic              pch_inc_nx;
  logic              pch_dec_nx;
  logic              busy_nx;
  logic              taken;
  logic [8:0]        sum;
  logic              cross_inc;
  logic              cross_dec;

  function automatic logic cond_true(input logic [3:0] op, input logic [7:0] st);
    logic res;
    case (op)
      4'd0:    res = ~st[C_BIT];
      4'd1:    res = st[C_BIT];
      4'd2:    res = st[Z_BIT];
      4'd3:    res = st[N_BIT];
      4'd4:    res = ~st[Z_BIT];
      4'd5:    res = ~st[N_BIT];
      4'd6:    res = ~st[V_BIT];
      4'd7:    res = st[V_BIT];
`ifdef BRANCH_BRA_EN
      4'd8:    res = 1'b1;
`else
      4'd8:    res = 1'b0;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign taken    = cond_true(branch_op, status);
  assign sum      = {1'b0, pcl} + {1'b0, offset};
  // Carry disagreeing with the displacement sign means the target left the current page.
  assign cross_inc = sum[8] & ~offset[7];
  assign cross_dec = ~sum[8] & offset[7];
  assign nmi_edge  = nmi_req & ~nmi_prev;

  // Next-state and next-output decode.
  always_comb begin
    state_nx      = state;
    branch_nx     = 1'b0;
    lower_byte_nx = 1'b0;
    normal_nx     = normal;
    vec_addr_nx   = vec_addr;
    pcl_new_nx    = pcl_new;
    pch_inc_nx    = 1'b0;
    pch_dec_nx    = 1'b0;
    busy_nx       = 1'b0;
    nmi_pend_nx   = nmi_pend | nmi_edge;
    case (state)
      VEC_LO: begin
        state_nx    = VEC_HI;
        branch_nx   = 1'b1;
        vec_addr_nx = vec_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        busy_nx     = 1'b1;
      end
      VEC_HI: begin
        state_nx  = IDLE;
        normal_nx = 1'b1;
      end
      IDLE: begin
        if (branch_uncon) begin
          branch_nx = 1'b1;
        end else if (branch_con) begin
          if (taken) begin
            branch_nx  = 1'b1;
            pcl_new_nx = sum[7:0];
            if (cross_inc || cross_dec) begin
              state_nx   = BR_FIX;
              busy_nx    = 1'b1;
              pch_inc_nx = cross_inc;
              pch_dec_nx = cross_dec;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            branch_nx = 1'b0;
          end
        end else if (instr_boundary && nmi_pend) begin
          state_nx      = VEC_LO;
          vec_addr_nx   = NMI_VEC;
          lower_byte_nx = 1'b1;
          busy_nx       = 1'b1;
          nmi_pend_nx   = nmi_edge;
        end else if (instr_boundary && irq_req && !status[I_BIT]) begin
          state_nx      = VEC_LO;
          vec_addr_nx   = IRQ_VEC;
          lower_byte_nx = 1'b1;
          busy_nx       = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      BR_FIX: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx      = VEC_LO;
        vec_addr_nx   = RST_VEC;
        lower_byte_nx = 1'b1;
        busy_nx       = 1'b1;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      state      <= VEC_LO;
      nmi_prev   <= 1'b0;
      nmi_pend   <= 1'b0;
      branch     <= 1'b0;
      lower_byte <= 1'b1;
      normal     <= 1'b0;
      vec_addr   <= RST_VEC;
      pcl_new    <= 8'h00;
      pch_inc    <= 1'b0;
      pch_dec    <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_nx;
      nmi_prev   <= nmi_req;
      nmi_pend   <= nmi_pend_nx;
      branch     <= branch_nx;
      lower_byte <= lower_byte_nx;
      normal     <= normal_nx;
      vec_addr   <= vec_addr_nx;
      pcl_new    <= pcl_new_nx;
      pch_inc    <= pch_inc_nx;
      pch_dec    <= pch_dec_nx;
      busy       <= busy_nx;
    end
  end

endmodule
